// File: rtl/pll_video_clken_gen.sv
// Multi-channel fractional clock-enable synthesiser for the video subsystem.
// Each channel runs a phase accumulator; its carry is the enable and its MSB the square wave.
module pll_video_clken_gen #(
    parameter int NUM_CLOCKS  = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INIT_INCR = {32'hA8F5C28F, 32'h80000000, 32'h80000000},
    localparam int SEL_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [ACC_W-1:0]      cfg_incr,
    input  logic [ACC_W-1:0]      cfg_phase,
    output logic [NUM_CLOCKS-1:0] clken,
    output logic [NUM_CLOCKS-1:0] clk_out,
    output logic                  locked
);

    localparam int                LCNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        S_UNLOCKED,
        S_LOCKED
    } lock_state_t;

    logic [ACC_W-1:0]      r_acc  [NUM_CLOCKS];
    logic [ACC_W-1:0]      r_incr [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] r_clken;
    logic [NUM_CLOCKS-1:0] r_clk_out;
    logic [ACC_W:0]        w_sum  [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] w_wr_hit;
    logic                  w_wr_valid;

    lock_state_t           r_state;
    lock_state_t           w_state_nxt;
    logic [LCNT_W-1:0]     r_lock_cnt;
    logic [LCNT_W-1:0]     w_lock_cnt_nxt;
    logic                  r_locked;

    // Writes to a channel index that does not exist are dropped without side effects.
    assign w_wr_valid = cfg_we && ({1'b0, cfg_sel} < (SEL_W + 1)'(NUM_CLOCKS));

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            w_sum[i]    = {1'b0, r_acc[i]} + {1'b0, r_incr[i]};
            w_wr_hit[i] = w_wr_valid && (cfg_sel == SEL_W'(i));
        end
    end

    // NOTE: the accumulator/increment arrays are reset explicitly because their
    // reset contents (zero phase, INIT_INCR rates) define the post-reset output sequence.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                r_acc[i]  <= '0;
                r_incr[i] <= INIT_INCR[i*ACC_W +: ACC_W];
            end
            r_clken   <= '0;
            r_clk_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (w_wr_hit[i]) begin
                    r_incr[i]    <= cfg_incr;
                    r_acc[i]     <= cfg_phase;
                    r_clken[i]   <= 1'b0;
                    r_clk_out[i] <= cfg_phase[ACC_W-1];
                end else begin
                    r_acc[i]     <= w_sum[i][ACC_W-1:0];
                    r_clken[i]   <= w_sum[i][ACC_W];
                    r_clk_out[i] <= w_sum[i][ACC_W-1];
                end
            end
        end
    end

    // NOTE: defaults first so every path assigns both next-state signals and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            S_UNLOCKED: begin
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                if (r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            default: begin
                w_lock_cnt_nxt = r_lock_cnt;
            end
        endcase
        if (w_wr_valid) begin
            w_state_nxt    = S_UNLOCKED;
            w_lock_cnt_nxt = '0;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state    <= S_UNLOCKED;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (w_state_nxt == S_LOCKED);
        end
    end

    assign clken   = r_clken;
    assign clk_out = r_clk_out;
    assign locked  = r_locked;

endmodule

// File: tb/tb_pll_video_clken_gen.sv
// Self-checking bench for pll_video_clken_gen: a reference model feeds a scoreboard
// every edge, and each scenario task adds its own checks of the documented behaviour.
module tb_pll_video_clken_gen;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int LC  = 16;
    localparam logic [NCH*AW-1:0] INIT = {32'hA8F5C28F, 32'h80000000, 32'h80000000};

    typedef struct packed {
        logic [NCH-1:0] clken;
        logic [NCH-1:0] clk_out;
        logic           locked;
    } exp_t;

    logic            refclk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic [AW-1:0]   cfg_incr;
    logic [AW-1:0]   cfg_phase;
    logic [NCH-1:0]  clken;
    logic [NCH-1:0]  clk_out;
    logic            locked;

    logic            mn_rst;
    logic            mn_we;
    logic [0:0]      mn_sel;
    logic [7:0]      mn_incr;
    logic [7:0]      mn_phase;
    logic [0:0]      mn_clken;
    logic [0:0]      mn_clk_out;
    logic            mn_locked;

    int              n_total = 0;
    int              n_bad   = 0;
    int              edge_k  = 0;
    exp_t            sb_q[$];

    logic [AW-1:0]   m_acc  [NCH];
    logic [AW-1:0]   m_incr [NCH];
    logic [NCH-1:0]  m_clken;
    logic [NCH-1:0]  m_clk_out;
    int              m_since;

    always #10 refclk = ~refclk;

    pll_video_clken_gen #(
        .NUM_CLOCKS (NCH),
        .ACC_W      (AW),
        .LOCK_CYCLES(LC),
        .INIT_INCR  (INIT)
    ) u_dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_incr (cfg_incr),
        .cfg_phase(cfg_phase),
        .clken    (clken),
        .clk_out  (clk_out),
        .locked   (locked)
    );

    pll_video_clken_gen #(
        .NUM_CLOCKS (1),
        .ACC_W      (8),
        .LOCK_CYCLES(1),
        .INIT_INCR  (8'hFF)
    ) u_min (
        .refclk   (refclk),
        .rst      (mn_rst),
        .cfg_we   (mn_we),
        .cfg_sel  (mn_sel),
        .cfg_incr (mn_incr),
        .cfg_phase(mn_phase),
        .clken    (mn_clken),
        .clk_out  (mn_clk_out),
        .locked   (mn_locked)
    );

    // Advances the model by one edge using the inputs currently driven, queues the
    // expectation, then pops it once the DUT has registered that edge.
    task automatic step(input string tag);
        exp_t        e;
        exp_t        got;
        logic [AW:0] s;
        logic        valid;
        valid = cfg_we && (int'(cfg_sel) < NCH);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i]  = '0;
                m_incr[i] = INIT[i*AW +: AW];
            end
            m_clken   = '0;
            m_clk_out = '0;
            m_since   = 0;
            edge_k    = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (valid && int'(cfg_sel) == i) begin
                    m_incr[i]    = cfg_incr;
                    m_acc[i]     = cfg_phase;
                    m_clken[i]   = 1'b0;
                    m_clk_out[i] = cfg_phase[AW-1];
                end else begin
                    s            = {1'b0, m_acc[i]} + {1'b0, m_incr[i]};
                    m_acc[i]     = s[AW-1:0];
                    m_clken[i]   = s[AW];
                    m_clk_out[i] = s[AW-1];
                end
            end
            if (valid) m_since = 0;
            else if (m_since < 1000) m_since = m_since + 1;
            edge_k = edge_k + 1;
        end
        e.clken   = m_clken;
        e.clk_out = m_clk_out;
        e.locked  = (m_since >= LC);
        sb_q.push_back(e);
        @(posedge refclk);
        #1;
        e           = sb_q.pop_front();
        got.clken   = clken;
        got.clk_out = clk_out;
        got.locked  = locked;
        n_total++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL sb_%s edge=%0d got clken=%b clk_out=%b locked=%b expected clken=%b clk_out=%b locked=%b",
                     tag, edge_k, got.clken, got.clk_out, got.locked, e.clken, e.clk_out, e.locked);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        cfg_we = 1'b0;
        step("reset");
        step("reset");
        rst = 1'b0;
    endtask

    task automatic run_default_seq(input string tag);
        int cnt2 = 0;
        for (int k = 1; k <= 101; k++) begin
            step(tag);
            n_total++;
            if (clken[1:0] !== ((k % 2 == 0) ? 2'b11 : 2'b00) ||
                clk_out[1:0] !== ((k % 2 == 1) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL %s_ch01 edge=%0d got clken=%b clk_out=%b", tag, k, clken[1:0], clk_out[1:0]);
            end
            n_total++;
            if (locked !== (k >= LC)) begin
                n_bad++;
                $display("FAIL %s_locked edge=%0d got %b expected %b", tag, k, locked, (k >= LC));
            end
            if (k >= 2 && clken[2]) cnt2++;
        end
        // 0xA8F5C28F is just under 0.66 * 2^32: edges 2..101 carry 66 times.
        n_total++;
        if (cnt2 != 66) begin
            n_bad++;
            $display("FAIL %s_ch2_count got %0d expected 66", tag, cnt2);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({clken, clk_out, locked} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got clken=%b clk_out=%b locked=%b expected all 0", clken, clk_out, locked);
        end
    endtask

    task automatic test_defaults();
        run_default_seq("defaults");
    endtask

    task automatic test_reprogram();
        do_reset();
        while (edge_k < 19) step("reprog");
        n_total++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL reprog_locked_before got %b expected 1", locked);
        end
        cfg_we    = 1'b1;
        cfg_sel   = 2'd0;
        cfg_incr  = 32'h40000000;
        cfg_phase = 32'h0;
        step("reprog_wr");
        cfg_we = 1'b0;
        n_total++;
        if (locked !== 1'b0 || clken[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reprog_write_edge got locked=%b clken0=%b expected 0 0", locked, clken[0]);
        end
        while (edge_k < 60) begin
            step("reprog");
            n_total++;
            if (clken[0] !== ((edge_k - 20) % 4 == 0) || clken[1] !== (edge_k % 2 == 0) ||
                locked !== (edge_k >= 36)) begin
                n_bad++;
                $display("FAIL reprog edge=%0d got clken=%b locked=%b", edge_k, clken, locked);
            end
        end
    endtask

    task automatic test_stop();
        cfg_we    = 1'b1;
        cfg_sel   = 2'd1;
        cfg_incr  = 32'h0;
        cfg_phase = 32'h80000000;
        for (int n = 0; n < 50; n++) begin
            step("stop");
            cfg_we = 1'b0;
            n_total++;
            if (clk_out[1] !== 1'b1 || clken[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL stop_ch1 n=%0d got clk_out1=%b clken1=%b expected 1 0", n, clk_out[1], clken[1]);
            end
        end
    endtask

    task automatic test_invalid();
        for (int n = 0; n < 5; n++) step("invalid_pre");
        cfg_we    = 1'b1;
        cfg_sel   = 2'd3;
        cfg_incr  = 32'hFFFFFFFF;
        cfg_phase = 32'h12345678;
        step("invalid_wr");
        cfg_we = 1'b0;
        for (int n = 0; n < 5; n++) begin
            n_total++;
            if (locked !== 1'b1) begin
                n_bad++;
                $display("FAIL invalid_locked n=%0d got %b expected 1", n, locked);
            end
            step("invalid_post");
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            cfg_we    = 1'b1;
            cfg_sel   = 2'(j % 3);
            cfg_incr  = 32'h10000000 * (j + 1);
            cfg_phase = 32'(j) << 28;
            step("b2b_wr");
            n_total++;
            if (locked !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_locked_wr j=%0d got %b expected 0", j, locked);
            end
        end
        cfg_we = 1'b0;
        for (int n = 1; n <= LC; n++) begin
            step("b2b_settle");
            n_total++;
            if (locked !== (n == LC)) begin
                n_bad++;
                $display("FAIL b2b_settle n=%0d got %b expected %b", n, locked, (n == LC));
            end
        end
    endtask

    task automatic test_reset_priority();
        for (int n = 0; n < 7; n++) step("rstpri_pre");
        rst       = 1'b1;
        cfg_we    = 1'b1;
        cfg_sel   = 2'd0;
        cfg_incr  = 32'h11111111;
        cfg_phase = 32'hFFFFFFFF;
        step("rstpri");
        cfg_we = 1'b0;
        rst    = 1'b0;
        n_total++;
        if ({clken, clk_out, locked} !== '0) begin
            n_bad++;
            $display("FAIL rstpri_outputs got clken=%b clk_out=%b locked=%b expected all 0", clken, clk_out, locked);
        end
        run_default_seq("rstpri");
    endtask

    task automatic test_min_params();
        int cnt = 0;
        @(posedge refclk);
        #1;
        n_total++;
        if (mn_clken !== 1'b0 || mn_clk_out !== 1'b0 || mn_locked !== 1'b0) begin
            n_bad++;
            $display("FAIL min_reset got clken=%b clk_out=%b locked=%b expected 0 0 0", mn_clken, mn_clk_out, mn_locked);
        end
        mn_rst = 1'b0;
        // incr=0xFF: acc after edge k is -k mod 256, so only edges leaving acc==0 (k=1,257) miss a carry.
        for (int k = 1; k <= 512; k++) begin
            @(posedge refclk);
            #1;
            if (mn_clken) cnt++;
            n_total++;
            if (mn_clken !== (k % 256 != 1) || mn_locked !== 1'b1) begin
                n_bad++;
                $display("FAIL min_edge k=%0d got clken=%b locked=%b expected %b 1", k, mn_clken, mn_locked, (k % 256 != 1));
            end
        end
        n_total++;
        if (cnt != 510) begin
            n_bad++;
            $display("FAIL min_count got %0d expected 510", cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = '0;
        cfg_incr  = '0;
        cfg_phase = '0;
        mn_rst    = 1'b1;
        mn_we     = 1'b0;
        mn_sel    = '0;
        mn_incr   = '0;
        mn_phase  = '0;
        test_reset();
        test_defaults();
        test_reprogram();
        test_stop();
        test_invalid();
        test_back_to_back();
        test_reset_priority();
        test_min_params();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
